// File: rtl/ascensor_pkg.sv
// Shared types for the elevator controller: FSM states, motion codes,
// and the request-code to target-floor decoder.
package ascensor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    SYNC,
    OPEN,
    CLOSE,
    WAIT
  } estado_t;

  localparam logic [1:0] ACC_STOP = 2'd0;
  localparam logic [1:0] ACC_UP   = 2'd1;
  localparam logic [1:0] ACC_DOWN = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [1:0] floor;
  } destino_t;

  localparam destino_t NO_TARGET = '{valid: 1'b0, floor: 2'd0};

  function automatic destino_t decode_piso(input logic [3:0] code);
    destino_t d;
    d = NO_TARGET;
    case (code)
      4'd1, 4'd5:        d = '{valid: 1'b1, floor: 2'd0};
      4'd2, 4'd6, 4'd7:  d = '{valid: 1'b1, floor: 2'd1};
      4'd3, 4'd8, 4'd9:  d = '{valid: 1'b1, floor: 2'd2};
      4'd4, 4'd10:       d = '{valid: 1'b1, floor: 2'd3};
      default:           d = NO_TARGET;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/control_ascensor_temporizador.sv
// Loadable down-counter shared by travel, sync, door and wait phases.
// Ports: clk, rst (sync, high), load, value (reload value), done (count==0).
module temporizador #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/control_ascensor.sv
// Elevator motion/door FSM between request memory and board outputs.
// Ports: clk, rst, memoria, abrir, cerrar -> piso, accion, puertas, le_req, llegada.
module control_ascensor
  import ascensor_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 100_000_000,
  parameter int DOOR_CYCLES   = 150_000_000,
  parameter int CNT_W         = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] memoria,
  input  logic       abrir,
  input  logic       cerrar,
  output logic [1:0] piso,
  output logic [1:0] accion,
  output logic       puertas,
  output logic       le_req,
  output logic       llegada
);

  localparam logic [CNT_W-1:0] T_MOVE = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_DOOR = CNT_W'(DOOR_CYCLES - 1);
  // SYNC lasts 3 cycles, WAIT 2: loaded as count-1.
  localparam logic [CNT_W-1:0] T_SYNC = CNT_W'(2);
  localparam logic [CNT_W-1:0] T_WAIT = CNT_W'(1);

  estado_t    state_q, state_d;
  logic [1:0] piso_q, piso_d;
  logic [1:0] accion_q, accion_d;
  logic       puertas_q, puertas_d;
  logic       le_req_q, le_req_d;
  logic       llegada_q, llegada_d;

  logic             t_load;
  logic [CNT_W-1:0] t_val;
  logic             t_done;

  destino_t dst;
  logic     aqui, sube, baja;

  assign dst  = decode_piso(memoria);
  assign aqui = dst.valid && (dst.floor == piso_q);
  // Limit rule folded in: no up-move from 3, no down-move from 0.
  assign sube = dst.valid && (dst.floor > piso_q) && (piso_q != 2'd3);
  assign baja = dst.valid && (dst.floor < piso_q) && (piso_q != 2'd0);

  temporizador #(.CNT_W(CNT_W)) u_tmr (
    .clk   (clk),
    .rst   (rst),
    .load  (t_load),
    .value (t_val),
    .done  (t_done)
  );

  always_comb begin
    state_d   = state_q;
    piso_d    = piso_q;
    accion_d  = accion_q;
    puertas_d = puertas_q;
    le_req_d  = 1'b0;
    llegada_d = 1'b0;
    t_load    = 1'b0;
    t_val     = '0;
    unique case (state_q)
      IDLE: begin
        accion_d  = ACC_STOP;
        puertas_d = 1'b0;
        if (aqui) begin
          state_d   = OPEN;
          puertas_d = 1'b1;
          t_load    = 1'b1;
          t_val     = T_DOOR;
        end else if (sube || baja) begin
          state_d  = MOVE;
          accion_d = sube ? ACC_UP : ACC_DOWN;
          t_load   = 1'b1;
          t_val    = T_MOVE;
        end
      end
      MOVE: begin
        if (t_done) begin
          piso_d    = (accion_q == ACC_UP) ? piso_q + 2'd1
                                           : piso_q - 2'd1;
          llegada_d = 1'b1;
          le_req_d  = 1'b1;
          state_d   = SYNC;
          t_load    = 1'b1;
          t_val     = T_SYNC;
        end
      end
      SYNC: begin
        if (t_done) begin
          state_d  = IDLE;
          accion_d = ACC_STOP;
          if (aqui) begin
            state_d   = OPEN;
            puertas_d = 1'b1;
            t_load    = 1'b1;
            t_val     = T_DOOR;
          end else if ((accion_q == ACC_UP && sube) ||
                       (accion_q == ACC_DOWN && baja)) begin
            state_d  = MOVE;
            accion_d = accion_q;
            t_load   = 1'b1;
            t_val    = T_MOVE;
          end
        end
      end
      OPEN: begin
        accion_d  = ACC_STOP;
        puertas_d = 1'b1;
        if (abrir) begin
          t_load = 1'b1;
          t_val  = T_DOOR;
        end else if (cerrar || t_done) begin
          state_d   = CLOSE;
          puertas_d = 1'b0;
          le_req_d  = 1'b1;
        end
      end
      CLOSE: begin
        state_d = WAIT;
        t_load  = 1'b1;
        t_val   = T_WAIT;
      end
      WAIT: begin
        if (t_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      piso_q    <= 2'd0;
      accion_q  <= ACC_STOP;
      puertas_q <= 1'b0;
      le_req_q  <= 1'b0;
      llegada_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      piso_q    <= piso_d;
      accion_q  <= accion_d;
      puertas_q <= puertas_d;
      le_req_q  <= le_req_d;
      llegada_q <= llegada_d;
    end
  end

  assign piso    = piso_q;
  assign accion  = accion_q;
  assign puertas = puertas_q;
  assign le_req  = le_req_q;
  assign llegada = llegada_q;

endmodule
